credit_rr_scheduler: RTL and testbench



---
 rtl/credit_rr_scheduler_pkg.sv | 19 +
 rtl/credit_rr_scheduler_if.sv | 37 +++
 rtl/credit_rr_scheduler_arb.sv | 38 +++
 rtl/credit_rr_scheduler.sv | 151 +++++++++++++++
 tb/tb_credit_rr_scheduler.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/credit_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// credit_sched_pkg
// Shared types for credit_rr_scheduler:
//   sched_state_e : scheduler FSM states (ST_INIT, ST_RUN)
//   cw_of()       : credit counter width for a given credit ceiling
// -----------------------------------------------------------------------------
package credit_sched_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } sched_state_e;

   // Width needed to hold 0..max_credits inclusive.
   function automatic int cw_of(input int max_credits);
      return $clog2(max_credits + 1);
   endfunction

endpackage

// File: rtl/credit_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// credit_rr_scheduler_if
// Requester-side and link-side signals of the credit round-robin scheduler.
//   req_valid / req_data / req_ready : per-requester push requests
//   push_valid / push_data           : registered push toward the link
//   push_credit                      : one credit returned per asserted cycle
//   push_receiver_in_reset           : receiver is in reset
//   push_sender_in_reset             : scheduler is in reset/init
// Handshake: requester i transfers its slice of req_data in a cycle where
// req_valid[i] & req_ready[i]; req_ready is one-hot or zero and may depend
// combinationally on req_valid. push_valid is a pulse per pushed payload with
// no backpressure; flow control is purely by credits.
// Modports: master = requester/link environment, slave = scheduler.
// -----------------------------------------------------------------------------
interface credit_rr_scheduler_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          push_valid;
   logic [DATA_WIDTH-1:0]         push_data;
   logic                          push_credit;
   logic                          push_receiver_in_reset;
   logic                          push_sender_in_reset;

   modport master (
      output req_valid, req_data, push_credit, push_receiver_in_reset,
      input  req_ready, push_valid, push_data, push_sender_in_reset
   );

   modport slave (
      input  req_valid, req_data, push_credit, push_receiver_in_reset,
      output req_ready, push_valid, push_data, push_sender_in_reset
   );
endinterface

// File: rtl/credit_rr_scheduler_arb.sv
// -----------------------------------------------------------------------------
// rr_arbiter_core
// Combinational round-robin pick: first asserted request searching from ptr_i
// upward with wrap.
//   req_i   : request vector
//   ptr_i   : search start index (always < N)
//   grant_o : one-hot grant or zero
//   idx_o   : index of the granted request (0 when none)
//   valid_o : a request was found
// -----------------------------------------------------------------------------
module rr_arbiter_core #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [PW-1:0] idx_o,
   output logic          valid_o
);
   int j;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N) j = j - N;
         if (!valid_o && req_i[j]) begin
            valid_o    = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = PW'(j);
         end
      end
   end
endmodule

// File: rtl/credit_rr_scheduler.sv
// -----------------------------------------------------------------------------
// credit_rr_scheduler
// Shares one credit-controlled push link among NUM_REQ requesters. Keeps a
// sender-side credit count, arbitrates round-robin while credits exceed the
// withhold level, and runs the link-reset handshake (INIT <-> RUN).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : requester and link signals, see credit_rr_scheduler_if
//   credit_initial      : credits loaded when leaving INIT (saturated to MAX)
//   credit_withhold     : credits held in reserve, sampled every cycle
//   credit_count        : current credits
//   credit_available    : credit_count > credit_withhold
//   credit_overflow     : sticky, a credit arrived while already at MAX
//   state_dbg           : current FSM state
// Optional (CREDIT_RR_SCHED_STATS_EN defined):
//   grant_total         : grants since rst / last entry to INIT (wraps)
//   stall_cycles        : RUN cycles with a request pending but no credit
// -----------------------------------------------------------------------------
module credit_rr_scheduler
   import credit_sched_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int DATA_WIDTH  = 8,
   parameter  int MAX_CREDITS = 4,
   localparam int CW          = cw_of(MAX_CREDITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   credit_rr_scheduler_if.slave  bus,
   input  logic [CW-1:0]         credit_initial,
   input  logic [CW-1:0]         credit_withhold,
   output logic [CW-1:0]         credit_count,
   output logic                  credit_available,
   output logic                  credit_overflow,
   output sched_state_e          state_dbg
`ifdef CREDIT_RR_SCHED_STATS_EN
   ,
   output logic [31:0]           grant_total,
   output logic [31:0]           stall_cycles
`endif
);
   localparam int            PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_CREDITS);

   sched_state_e          state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic [PW-1:0]         ptr_q, ptr_d;
   logic                  pv_q;
   logic [DATA_WIDTH-1:0] pd_q, pd_d;
   logic [NUM_REQ-1:0]    arb_grant, grant;
   logic [PW-1:0]         arb_idx;
   logic                  arb_valid;
   logic                  avail;
   logic                  do_grant;

   assign avail = (count_q > credit_withhold);

   rr_arbiter_core #(.N(NUM_REQ)) u_arb (
      .req_i   (bus.req_valid),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      ptr_d    = ptr_q;
      pd_d     = pd_q;
      grant    = '0;
      do_grant = 1'b0;
      case (state_q)
         ST_INIT: begin
            // Credits returned while in INIT are ignored.
            if (!bus.push_receiver_in_reset) begin
               state_d = ST_RUN;
               count_d = (credit_initial > MAX_C) ? MAX_C : credit_initial;
            end
         end
         ST_RUN: begin
            if (bus.push_receiver_in_reset) begin
               // Pointer deliberately kept across the link reset.
               state_d = ST_INIT;
               count_d = '0;
            end else begin
               do_grant = avail & arb_valid;
               if (do_grant) begin
                  grant = arb_grant;
                  ptr_d = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                  pd_d  = bus.req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
               end
               // Return and grant together cancel out. Underflow cannot
               // happen: a grant needs count > withhold >= 0.
               if (bus.push_credit && !do_grant) begin
                  if (count_q == MAX_C) ovf_d = 1'b1;
                  else                  count_d = count_q + 1'b1;
               end else if (!bus.push_credit && do_grant) begin
                  count_d = count_q - 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         count_q <= '0;
         ovf_q   <= 1'b0;
         ptr_q   <= '0;
         pv_q    <= 1'b0;
         pd_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         ptr_q   <= ptr_d;
         pv_q    <= do_grant;
         pd_q    <= pd_d;
      end
   end

   assign bus.req_ready            = grant;
   assign bus.push_valid           = pv_q;
   assign bus.push_data            = pd_q;
   assign bus.push_sender_in_reset = (state_q == ST_INIT);
   assign credit_count             = count_q;
   assign credit_available         = avail;
   assign credit_overflow          = ovf_q;
   assign state_dbg                = state_q;

`ifdef CREDIT_RR_SCHED_STATS_EN
   logic [31:0] gt_q, sc_q;

   always_ff @(posedge clk) begin
      if (rst || (state_q == ST_RUN && state_d == ST_INIT)) gt_q <= '0;
      else if (do_grant)                                    gt_q <= gt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) sc_q <= '0;
      else if (state_q == ST_RUN && (|bus.req_valid) && !avail) sc_q <= sc_q + 32'd1;
   end

   assign grant_total  = gt_q;
   assign stall_cycles = sc_q;
`endif
endmodule

// File: tb/tb_credit_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_credit_rr_scheduler
// Table of per-cycle vectors for credit_rr_scheduler (NUM_REQ=4, DATA_WIDTH=8,
// MAX_CREDITS=4). Inputs are driven 1 time unit after the rising edge and
// outputs are checked on the falling edge. Payloads of expected grants go to
// a queue and are matched against push_data one cycle later.
// -----------------------------------------------------------------------------
module tb_credit_rr_scheduler;
   import credit_sched_pkg::*;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int CW = 3;

   typedef struct {
      logic          rst;
      logic          recv;
      logic          cred;
      logic [NR-1:0] valid;
      logic [CW-1:0] init;
      logic [CW-1:0] wh;
      logic [NR-1:0] exp_rdy;
      logic [CW-1:0] exp_cnt;
      logic          exp_av;
      logic          exp_sir;
      logic          exp_ovf;
   } vec_t;

   logic clk;
   logic rst;
   logic [CW-1:0] credit_initial;
   logic [CW-1:0] credit_withhold;
   logic [CW-1:0] credit_count;
   logic          credit_available;
   logic          credit_overflow;
   sched_state_e  state_dbg;
`ifdef CREDIT_RR_SCHED_STATS_EN
   logic [31:0] grant_total;
   logic [31:0] stall_cycles;
`endif

   credit_rr_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   credit_rr_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_CREDITS(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus),
      .credit_initial   (credit_initial),
      .credit_withhold  (credit_withhold),
      .credit_count     (credit_count),
      .credit_available (credit_available),
      .credit_overflow  (credit_overflow),
      .state_dbg        (state_dbg)
`ifdef CREDIT_RR_SCHED_STATS_EN
      ,
      .grant_total      (grant_total),
      .stall_cycles     (stall_cycles)
`endif
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [DW-1:0] exp_q[$];
   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic vec_t mk(input logic r, input logic rv, input logic c,
                               input logic [NR-1:0] v, input int ini, input int wh,
                               input logic [NR-1:0] rdy, input int cnt,
                               input logic av, input logic sir, input logic ovf);
      vec_t t;
      t.rst = r;  t.recv = rv; t.cred = c; t.valid = v;
      t.init = CW'(ini); t.wh = CW'(wh);
      t.exp_rdy = rdy; t.exp_cnt = CW'(cnt);
      t.exp_av = av; t.exp_sir = sir; t.exp_ovf = ovf;
      return t;
   endfunction

   function automatic int onehot_idx(input logic [NR-1:0] oh);
      int r = 0;
      for (int i = 0; i < NR; i++) if (oh[i]) r = i;
      return r;
   endfunction

   initial begin
      logic [NR-1:0]    prev_rdy;
      logic             prev_rst;
      logic [NR*DW-1:0] d;
      logic [DW-1:0]    e;
      vec_t             v;
      logic             released;

      // ---- init handshake: receiver held in reset 5 cycles
      for (int i = 0; i < 5; i++) vecs.push_back(mk(0,1,0,4'b0000,3,0, 4'b0000,0,0,1,0));
      vecs.push_back(mk(0,0,0,4'b0000,3,0, 4'b0000,0,0,1,0));
      vecs.push_back(mk(0,0,0,4'b0000,3,0, 4'b0000,3,1,0,0));
      // ---- credit exhaustion with initial=2
      vecs.push_back(mk(0,1,0,4'b0000,2,0, 4'b0000,3,1,0,0));
      vecs.push_back(mk(0,0,0,4'b0000,2,0, 4'b0000,0,0,1,0));
      vecs.push_back(mk(0,0,0,4'b1111,2,0, 4'b0001,2,1,0,0));
      vecs.push_back(mk(0,0,0,4'b1111,2,0, 4'b0010,1,1,0,0));
      vecs.push_back(mk(0,0,0,4'b1111,2,0, 4'b0000,0,0,0,0));
      vecs.push_back(mk(0,0,0,4'b1111,2,0, 4'b0000,0,0,0,0));
      vecs.push_back(mk(0,0,1,4'b1111,2,0, 4'b0000,0,0,0,0));
      vecs.push_back(mk(0,0,0,4'b1111,2,0, 4'b0100,1,1,0,0));
      vecs.push_back(mk(0,0,0,4'b0000,2,0, 4'b0000,0,0,0,0));
      // ---- round robin with continuous credit return (pointer starts at 3)
      vecs.push_back(mk(0,0,1,4'b0000,2,0, 4'b0000,0,0,0,0));
      vecs.push_back(mk(0,0,1,4'b1011,2,0, 4'b1000,1,1,0,0));
      vecs.push_back(mk(0,0,1,4'b1011,2,0, 4'b0001,1,1,0,0));
      vecs.push_back(mk(0,0,1,4'b1011,2,0, 4'b0010,1,1,0,0));
      vecs.push_back(mk(0,0,1,4'b1011,2,0, 4'b1000,1,1,0,0));
      vecs.push_back(mk(0,0,1,4'b1011,2,0, 4'b0001,1,1,0,0));
      vecs.push_back(mk(0,0,1,4'b1011,2,0, 4'b0010,1,1,0,0));
      // ---- fill to MAX then overflow, sticky
      vecs.push_back(mk(0,0,1,4'b0000,2,0, 4'b0000,1,1,0,0));
      vecs.push_back(mk(0,0,1,4'b0000,2,0, 4'b0000,2,1,0,0));
      vecs.push_back(mk(0,0,1,4'b0000,2,0, 4'b0000,3,1,0,0));
      vecs.push_back(mk(0,0,1,4'b0000,2,0, 4'b0000,4,1,0,0));
      vecs.push_back(mk(0,0,0,4'b0000,2,0, 4'b0000,4,1,0,1));
      vecs.push_back(mk(0,0,0,4'b0100,2,0, 4'b0100,4,1,0,1));
      // ---- withhold: initial=3, withhold=2 -> single grant
      vecs.push_back(mk(0,1,0,4'b0000,3,2, 4'b0000,3,1,0,1));
      vecs.push_back(mk(0,0,0,4'b0000,3,2, 4'b0000,0,0,1,1));
      vecs.push_back(mk(0,0,0,4'b1111,3,2, 4'b1000,3,1,0,1));
      vecs.push_back(mk(0,0,0,4'b1111,3,2, 4'b0000,2,0,0,1));
      vecs.push_back(mk(0,0,0,4'b1111,3,2, 4'b0000,2,0,0,1));
      vecs.push_back(mk(0,0,1,4'b0000,3,0, 4'b0000,2,1,0,1));
      // ---- receiver reset with a push in flight; credit in INIT ignored
      vecs.push_back(mk(0,0,1,4'b0001,4,0, 4'b0001,3,1,0,1));
      vecs.push_back(mk(0,1,0,4'b1111,4,0, 4'b0000,3,1,0,1));
      vecs.push_back(mk(0,1,1,4'b1111,4,0, 4'b0000,0,0,1,1));
      vecs.push_back(mk(0,0,0,4'b0000,4,0, 4'b0000,0,0,1,1));
      vecs.push_back(mk(0,0,0,4'b0000,4,0, 4'b0000,4,1,0,1));
      // ---- rst with a push pending
      vecs.push_back(mk(0,0,0,4'b0010,4,0, 4'b0010,4,1,0,1));
      vecs.push_back(mk(1,0,0,4'b0000,4,0, 4'b0000,3,1,0,1));
      vecs.push_back(mk(1,0,0,4'b0000,4,0, 4'b0000,0,0,1,0));

      // ---- power-on reset
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_data = '0;
      bus.push_credit = 1'b0;
      bus.push_receiver_in_reset = 1'b1;
      credit_initial = 3'd3;
      credit_withhold = 3'd0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_push_valid", 32'(bus.push_valid), 32'd0);
      chk("rst_push_data",  32'(bus.push_data), 32'd0);
      chk("rst_req_ready",  32'(bus.req_ready), 32'd0);
      chk("rst_count",      32'(credit_count), 32'd0);
      chk("rst_overflow",   32'(credit_overflow), 32'd0);
      chk("rst_sender_in_reset", 32'(bus.push_sender_in_reset), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      prev_rdy = '0;
      prev_rst = 1'b0;
      for (int n = 0; n < vecs.size(); n++) begin
         v = vecs[n];
         d = NR*DW'($urandom());
         rst = v.rst;
         bus.push_receiver_in_reset = v.recv;
         bus.push_credit = v.cred;
         bus.req_valid = v.valid;
         bus.req_data = d;
         credit_initial = v.init;
         credit_withhold = v.wh;
         @(negedge clk);
         chk($sformatf("v%0d_ready", n), 32'(bus.req_ready), 32'(v.exp_rdy));
         chk($sformatf("v%0d_count", n), 32'(credit_count), 32'(v.exp_cnt));
         chk($sformatf("v%0d_avail", n), 32'(credit_available), 32'(v.exp_av));
         chk($sformatf("v%0d_sender_in_reset", n), 32'(bus.push_sender_in_reset), 32'(v.exp_sir));
         chk($sformatf("v%0d_state", n), 32'(state_dbg), v.exp_sir ? 32'(ST_INIT) : 32'(ST_RUN));
         chk($sformatf("v%0d_overflow", n), 32'(credit_overflow), 32'(v.exp_ovf));
         chk($sformatf("v%0d_push_valid", n), 32'(bus.push_valid),
             32'((prev_rdy != '0) && !prev_rst));
         if ((prev_rdy != '0) && !prev_rst && bus.push_valid) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("v%0d_sb_underrun", n), 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("v%0d_push_data", n), 32'(bus.push_data), 32'(e));
            end
         end
         if (v.exp_rdy != '0) exp_q.push_back(d[onehot_idx(v.exp_rdy)*DW +: DW]);
         prev_rdy = v.exp_rdy;
         prev_rst = v.rst;
         @(posedge clk);
         #1;
      end

      // ---- release after rst: bounded wait for the sender to leave INIT
      rst = 1'b0;
      bus.push_receiver_in_reset = 1'b0;
      bus.push_credit = 1'b0;
      bus.req_valid = '0;
      credit_initial = 3'd4;
      credit_withhold = 3'd0;
      released = 1'b0;
      for (int i = 0; i < 10 && !released; i++) begin
         @(negedge clk);
         if (!bus.push_sender_in_reset) released = 1'b1;
      end
      chk("release_within_budget", 32'(released), 32'd1);
      chk("release_count", 32'(credit_count), 32'd4);
      @(posedge clk);
      #1;
      bus.req_valid = 4'b1111;
      @(negedge clk);
      chk("ptr_reset_grant", 32'(bus.req_ready), 32'b0001);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      @(negedge clk);
      chk("post_rst_push_valid", 32'(bus.push_valid), 32'd1);
      chk("post_rst_count", 32'(credit_count), 32'd3);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
